// File: rtl/clock_divider_mc_if.sv
// Control/status bundle for clock_divider_mc. The optional wr_duty field is
// present only when CLKDIV_DUTY_EN is defined.
interface clock_divider_mc_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 24
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // wr_en is a one-cycle write strobe with no back-pressure: the divider
  // accepts it on every edge it is high; wr_ch values >= N_CH are dropped.
  logic [N_CH-1:0]  enable;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] wr_duty;
`endif
  logic [N_CH-1:0]  div_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  modport master (
    output enable, sync, wr_en, wr_ch, wr_div, wr_mode,
`ifdef CLKDIV_DUTY_EN
    output wr_duty,
`endif
    input  div_out, tick, pending
  );

  modport slave (
    input  enable, sync, wr_en, wr_ch, wr_div, wr_mode,
`ifdef CLKDIV_DUTY_EN
    input  wr_duty,
`endif
    output div_out, tick, pending
  );
endinterface

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable divider/tick generator with double-buffered
// divisor/mode updates. Define CLKDIV_DUTY_EN to turn pulse mode into PWM.
module clock_divider_mc #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 24,
  parameter int RESET_DIV = 12000
) (
  input logic               clk,
  input logic               rst,
  clock_divider_mc_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] div_a_q [N_CH];
  logic [CNT_W-1:0] div_a_d [N_CH];
  logic [CNT_W-1:0] div_s_q [N_CH];
  logic [CNT_W-1:0] div_s_d [N_CH];
  logic [N_CH-1:0]  mode_a_q, mode_a_d, mode_s_q, mode_s_d;
  logic [N_CH-1:0]  pend_q, pend_d, out_q, out_d, tick_q, tick_d;
  logic [N_CH-1:0]  wr_hit, pend_any, term, apply;
`ifdef CLKDIV_DUTY_EN
  localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'(RESET_DIV / 2);
  logic [CNT_W-1:0] duty_a_q [N_CH];
  logic [CNT_W-1:0] duty_a_d [N_CH];
  logic [CNT_W-1:0] duty_s_q [N_CH];
  logic [CNT_W-1:0] duty_s_d [N_CH];
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i]   = bus.wr_en && (bus.wr_ch == CH_W'(i));
      div_s_d[i]  = wr_hit[i] ? bus.wr_div  : div_s_q[i];
      mode_s_d[i] = wr_hit[i] ? bus.wr_mode : mode_s_q[i];
      pend_any[i] = pend_q[i] | wr_hit[i];
      term[i]     = bus.enable[i] && (div_a_q[i] != '0) && (cnt_q[i] >= div_a_q[i] - ONE);
      // A halted channel has no period boundary to wait for, so it takes
      // the shadow straight away; sync forces every shadow in.
      apply[i]    = bus.sync || (pend_any[i] && (term[i] || (div_a_q[i] == '0)));
      div_a_d[i]  = apply[i] ? div_s_d[i]  : div_a_q[i];
      mode_a_d[i] = apply[i] ? mode_s_d[i] : mode_a_q[i];
      pend_d[i]   = pend_any[i] && !apply[i];
`ifdef CLKDIV_DUTY_EN
      duty_s_d[i] = wr_hit[i] ? bus.wr_duty : duty_s_q[i];
      duty_a_d[i] = apply[i] ? duty_s_d[i] : duty_a_q[i];
`endif

      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      out_d[i]  = out_q[i];
      if (bus.sync || (div_a_q[i] == '0)) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end else if (term[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        if (mode_a_d[i] != mode_a_q[i]) out_d[i] = 1'b0;
        else if (mode_a_q[i])           out_d[i] = 1'b1;
        else                            out_d[i] = ~out_q[i];
      end else begin
        if (bus.enable[i]) cnt_d[i] = cnt_q[i] + ONE;
        if (mode_a_q[i])   out_d[i] = 1'b0;
      end
`ifdef CLKDIV_DUTY_EN
      // PWM output is a compare against the count this edge will hold.
      if (!bus.sync && (div_a_q[i] != '0) && mode_a_q[i] && mode_a_d[i])
        out_d[i] = (div_a_d[i] != '0) && (cnt_d[i] < duty_a_d[i]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= '0;
        div_a_q[i] <= RST_D;
        div_s_q[i] <= RST_D;
`ifdef CLKDIV_DUTY_EN
        duty_a_q[i] <= RST_DUTY;
        duty_s_q[i] <= RST_DUTY;
`endif
      end
      mode_a_q <= '0;
      mode_s_q <= '0;
      pend_q   <= '0;
      out_q    <= '0;
      tick_q   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        div_a_q[i] <= div_a_d[i];
        div_s_q[i] <= div_s_d[i];
`ifdef CLKDIV_DUTY_EN
        duty_a_q[i] <= duty_a_d[i];
        duty_s_q[i] <= duty_s_d[i];
`endif
      end
      mode_a_q <= mode_a_d;
      mode_s_q <= mode_s_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.div_out = out_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pend_q;
endmodule
